// File: rtl/i2c_pkg.sv
// i2c_pkg: I2C command encodings and arbiter state encoding shared by the arbiter slice.
package i2c_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'b00;
    localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
    localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
    localparam logic [1:0] I2C_CMD_READ  = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_FSTOP_ISSUE,
        ARB_FSTOP_WAIT
    } arb_state_e;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// rr_pick: round-robin one-hot picker, first set request at or after ptr_i wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    // Scan from farthest to nearest so the nearest request overwrites the others.
    always_comb begin
        gnt_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_i) + k;
            idx = idx >= N ? idx - N : idx;
            if (req_i[idx]) gnt_o = N'(1) << idx;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one i2c_master command port between N_REQ requesters with watchdog and forced-STOP recovery.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_lock_i,
    output logic [N_REQ-1:0]     req_grant_o,
    input  logic [2*N_REQ-1:0]   req_cmd_i,
    input  logic [8*N_REQ-1:0]   req_data_in_i,
    input  logic [N_REQ-1:0]     req_ack_in_i,
    input  logic [N_REQ-1:0]     req_stb_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           req_data_out_o,
    output logic                 req_ack_out_o,
    output logic [1:0]           m_cmd_o,
    output logic [7:0]           m_data_in_o,
    output logic                 m_ack_in_o,
    output logic                 m_stb_o,
    input  logic                 m_ready_i,
    input  logic [7:0]           m_data_out_i,
    input  logic                 m_ack_out_i,
    output logic                 err_timeout_o
);

    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    arb_state_e           state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     evicted_q, evicted_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 bus_open_q, bus_open_d;
    logic                 err_q, err_d;

    logic [PW-1:0]        owner_idx, next_ptr;
    logic [1:0]           own_cmd;
    logic [7:0]           own_data;
    logic                 own_ack, own_lock;
    logic                 fwd_stb, fstop_stb;
    logic [N_REQ-1:0]     pick_gnt;
    logic                 pick_valid;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req_i   (req_lock_i & ~evicted_q),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    always_comb begin
        owner_idx = '0;
        own_cmd   = '0;
        own_data  = '0;
        own_ack   = 1'b0;
        own_lock  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
                own_cmd   = req_cmd_i[2*i +: 2];
                own_data  = req_data_in_i[8*i +: 8];
                own_ack   = req_ack_in_i[i];
                own_lock  = req_lock_i[i];
            end
        end
    end

    assign fwd_stb   = state_q == ARB_OWNED && |(req_stb_i & grant_q);
    assign fstop_stb = state_q == ARB_FSTOP_ISSUE && m_ready_i;
    assign next_ptr  = owner_idx == PW'(N_REQ - 1) ? '0 : owner_idx + PW'(1);

    assign m_stb_o        = fwd_stb | fstop_stb;
    assign m_cmd_o        = state_q == ARB_FSTOP_ISSUE ? I2C_CMD_STOP : own_cmd;
    assign m_data_in_o    = own_data;
    assign m_ack_in_o     = own_ack;
    assign req_ready_o    = {N_REQ{m_ready_i}} & grant_q;
    assign req_grant_o    = grant_q;
    assign req_data_out_o = m_data_out_i;
    assign req_ack_out_o  = m_ack_out_i;
    assign err_timeout_o  = err_q;

    // A command strobed in the release cycle still updates bus_open before the release decision.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        wdog_d     = wdog_q;
        err_d      = 1'b0;
        evicted_d  = evicted_q & req_lock_i;
        bus_open_d = fwd_stb && own_cmd == I2C_CMD_START ? 1'b1 :
                     (fwd_stb && own_cmd == I2C_CMD_STOP) || fstop_stb ? 1'b0 : bus_open_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (m_ready_i && pick_valid) begin
                    grant_d = pick_gnt;
                    wdog_d  = '0;
                    state_d = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (!own_lock) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = bus_open_d ? ARB_FSTOP_ISSUE : ARB_IDLE;
                end else if (fwd_stb) begin
                    wdog_d = '0;
                end else if (&wdog_q) begin
                    err_d     = 1'b1;
                    grant_d   = '0;
                    evicted_d = evicted_q | grant_q;
                    ptr_d     = next_ptr;
                    wdog_d    = '0;
                    state_d   = bus_open_d ? ARB_FSTOP_ISSUE : ARB_IDLE;
                end else if (m_ready_i) begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            ARB_FSTOP_ISSUE: state_d = m_ready_i ? ARB_FSTOP_WAIT : ARB_FSTOP_ISSUE;
            ARB_FSTOP_WAIT:  state_d = m_ready_i ? ARB_IDLE : ARB_FSTOP_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            evicted_q  <= '0;
            ptr_q      <= '0;
            wdog_q     <= '0;
            bus_open_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            evicted_q  <= evicted_d;
            ptr_q      <= ptr_d;
            wdog_q     <= wdog_d;
            bus_open_q <= bus_open_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed self-checking bench for i2c_bus_arbiter with a small i2c_master stand-in.
module tb_i2c_bus_arbiter;
    import i2c_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  lock = '0, stb = '0, ack = '0;
    logic [3:0]  cmd = '0;
    logic [15:0] din = '0;
    logic [1:0]  grant, ready;
    logic [7:0]  rdata;
    logic        rack;
    logic [1:0]  m_cmd;
    logic [7:0]  m_din;
    logic        m_ack, m_stb, m_ready, err;
    logic [7:0]  m_dout = 8'hA5;
    logic        m_aout = 1'b1;

    int          n_cmp = 0, n_bad = 0, err_cnt = 0, log_n = 0, busy;
    logic [1:0]  log_cmd [256];
    logic [7:0]  log_dat [256];

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.N_REQ(2), .TIMEOUT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_lock_i(lock), .req_grant_o(grant), .req_cmd_i(cmd), .req_data_in_i(din),
        .req_ack_in_i(ack), .req_stb_i(stb), .req_ready_o(ready),
        .req_data_out_o(rdata), .req_ack_out_o(rack),
        .m_cmd_o(m_cmd), .m_data_in_o(m_din), .m_ack_in_o(m_ack), .m_stb_o(m_stb),
        .m_ready_i(m_ready), .m_data_out_i(m_dout), .m_ack_out_i(m_aout),
        .err_timeout_o(err)
    );

    // Master stand-in: logs each accepted strobe, then stays busy for two cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            busy    <= 0;
        end else if (m_stb && m_ready) begin
            log_cmd[log_n] <= m_cmd;
            log_dat[log_n] <= m_din;
            log_n          <= log_n + 1;
            m_ready        <= 1'b0;
            busy           <= 1;
        end else if (!m_ready) begin
            if (busy == 0) m_ready <= 1'b1;
            else busy <= busy - 1;
        end
    end

    always @(posedge clk) if (err) err_cnt <= err_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        lock  = '0;
        stb   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input int r, input logic [1:0] c, input logic [7:0] d);
        int k = 0;
        while (!ready[r] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("send_ready_timeout", 32'(k), 0);
        cmd[2*r +: 2] = c;
        din[8*r +: 8] = d;
        stb[r]        = 1'b1;
        @(negedge clk);
        stb[r]        = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int k = 0;
        while (grant == 2'b00 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(grant), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int base, k, e0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_m_stb", 32'(m_stb), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single owner, full transaction
        base    = log_n;
        lock[0] = 1'b1;
        chk("t1_grant_pre", 32'(grant), 0);
        @(negedge clk);
        chk("t1_grant_lat", 32'(grant), 32'(2'b01));
        send(0, I2C_CMD_START, 8'h00);
        send(0, I2C_CMD_WRITE, 8'h14);
        send(0, I2C_CMD_WRITE, 8'h00);
        send(0, I2C_CMD_STOP, 8'h00);
        lock[0] = 1'b0;
        @(negedge clk);
        chk("t1_grant_rel", 32'(grant), 0);
        repeat (5) @(negedge clk);
        chk("t1_count", 32'(log_n - base), 4);
        chk("t1_cmds", 32'({log_cmd[base], log_cmd[base+1], log_cmd[base+2], log_cmd[base+3]}), 32'(8'b00_10_10_01));
        chk("t1_d1", 32'(log_dat[base+1]), 32'h14);
        chk("t1_d2", 32'(log_dat[base+2]), 32'h00);
        chk("t1_rdata", 32'(rdata), 32'hA5);
        chk("t1_grant_idle", 32'(grant), 0);

        // Round robin alternation, plus non-owner strobe ignored
        do_reset();
        base = log_n;
        lock = 2'b11;
        @(negedge clk);
        chk("t2_first", 32'(grant), 32'(2'b01));
        chk("t3_ready1", 32'(ready[1]), 0);
        cmd[3:2] = I2C_CMD_WRITE;
        stb[1]   = 1'b1;
        #1;
        chk("t3_m_stb", 32'(m_stb), 0);
        @(negedge clk);
        stb[1] = 1'b0;
        chk("t3_nolog", 32'(log_n - base), 0);
        lock[0] = 1'b0;
        @(negedge clk);
        chk("t2_rel0", 32'(grant), 0);
        @(negedge clk);
        chk("t2_second", 32'(grant), 32'(2'b10));
        lock = 2'b01;
        @(negedge clk);
        chk("t2_rel1", 32'(grant), 0);
        @(negedge clk);
        chk("t2_third", 32'(grant), 32'(2'b01));
        lock = 2'b10;
        @(negedge clk);
        chk("t2_rel2", 32'(grant), 0);
        @(negedge clk);
        chk("t2_fourth", 32'(grant), 32'(2'b10));
        lock = 2'b00;
        repeat (3) @(negedge clk);

        // Release with bus open forces exactly one STOP
        do_reset();
        base    = log_n;
        e0      = err_cnt;
        lock[0] = 1'b1;
        wait_grant("t4_grant", 2'b01);
        send(0, I2C_CMD_START, 8'h00);
        send(0, I2C_CMD_WRITE, 8'h55);
        lock[0] = 1'b0;
        @(negedge clk);
        chk("t4_grant_rel", 32'(grant), 0);
        repeat (10) @(negedge clk);
        chk("t4_count", 32'(log_n - base), 3);
        chk("t4_stop", 32'(log_cmd[base+2]), 32'(2'b01));
        chk("t4_no_err", 32'(err_cnt - e0), 0);

        // Watchdog eviction after START and idle
        do_reset();
        base    = log_n;
        e0      = err_cnt;
        lock[0] = 1'b1;
        wait_grant("t5_grant", 2'b01);
        send(0, I2C_CMD_START, 8'h00);
        k = 1;
        while (!err && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t5_err_cycle", 32'(k), 19);
        chk("t5_grant_evict", 32'(grant), 0);
        repeat (6) @(negedge clk);
        chk("t5_count", 32'(log_n - base), 2);
        chk("t5_fstop", 32'(log_cmd[base+1]), 32'(2'b01));
        chk("t5_err_once", 32'(err_cnt - e0), 1);
        repeat (5) @(negedge clk);
        chk("t5_no_regrant", 32'(grant), 0);
        lock[0] = 1'b0;
        @(negedge clk);
        lock[0] = 1'b1;
        wait_grant("t5_regrant", 2'b01);
        lock[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Strobe in the expiry cycle beats the watchdog
        do_reset();
        e0      = err_cnt;
        lock[0] = 1'b1;
        wait_grant("t6_grant", 2'b01);
        send(0, I2C_CMD_START, 8'h00);
        for (int j = 1; j < 18; j++) @(negedge clk);
        send(0, I2C_CMD_WRITE, 8'h77);
        chk("t6_no_err", 32'(err_cnt - e0), 0);
        chk("t6_err_sig", 32'(err), 0);
        chk("t6_still_owned", 32'(grant), 32'(2'b01));
        lock[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-WRITE
        do_reset();
        base    = log_n;
        lock[0] = 1'b1;
        wait_grant("t7_grant", 2'b01);
        send(0, I2C_CMD_START, 8'h00);
        while (!ready[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        cmd[1:0] = I2C_CMD_WRITE;
        stb[0]   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t7_grant", 32'(grant), 0);
        chk("t7_m_stb", 32'(m_stb), 0);
        chk("t7_ready", 32'(ready), 0);
        chk("t7_err", 32'(err), 0);
        stb  = '0;
        lock = '0;
        @(negedge clk);
        chk("t7_nolog", 32'(log_n - base), 1);
        rst_n   = 1'b1;
        lock[1] = 1'b1;
        @(negedge clk);
        chk("t7_fresh", 32'(grant), 32'(2'b10));
        lock = '0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
